sync_sum_join: RTL and testbench
================================

Name: sync_sum_join

Overview:
- Clocked two-input join-and-add stage for the SNN datapath.
- Waits for both input channels to request, then adds their data and presents the result on one output channel.
- Uses 4-phase (return-to-zero) req/ack on all channels.
- Internally: inverter on R_ack, two-stage C-element join (input join, then gating by the inverted R_ack), unsigned adder, and an output hold register (the latch equivalent).

Parameters:
- WIDTH_IN, 8: width of each input operand.
- WIDTH_OUT, 13: width of the result. Must be >= WIDTH_IN+1; elaboration error otherwise.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- L1_req  in  1  request, input channel 1.
- L1_data  in  WIDTH_IN  operand 1; stable while L1_req=1.
- L1_ack  out  1  acknowledge, channel 1.
- L2_req  in  1  request, input channel 2.
- L2_data  in  WIDTH_IN  operand 2; stable while L2_req=1.
- L2_ack  out  1  acknowledge, channel 2.
- R_req  out  1  output request.
- R_data  out  WIDTH_OUT  sum output.
- R_ack  in  1  output acknowledge from consumer.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state register `s` <= 0.
  - input-join C-element register `j` <= 0.
  - R_data <= 0.
  - All outputs are therefore 0 on the cycle after reset.
- Input join C-element `j`, updated every clock edge:
  - j <= 1 if L1_req & L2_req.
  - j <= 0 if !L1_req & !L2_req.
  - Otherwise j holds.
- Output state C-element `s`, updated every clock edge, with nack = !R_ack:
  - s <= 1 if j & nack.
  - s <= 0 if !j & !nack.
  - Otherwise s holds.
- L1_ack = L2_ack = R_req = s. Outputs are direct register outputs; no combinational path from inputs.
- Adder is combinational: sum = zero-extend(L1_data) + zero-extend(L2_data), computed at WIDTH_OUT bits. No overflow is possible.
- Output hold register (transparent-latch equivalent):
  - When next value of s is 1, R_data <= sum.
  - Otherwise R_data holds.
  - R_data is valid on the same cycle R_req rises and stays stable while s=0.
- Latency: both req high at edge N, R_ack=0 → j=1 after edge N → s=1 and R_req=1 after edge N+1 (2 cycles).
- Return-to-zero: both req low and R_ack=1 → j=0 after one edge → s=0 after the next edge.
- Boundary cases:
  - Only one req high: j holds, so no output event and no ack.
  - Req pair drops while R_ack is still 0: s holds 1 until R_ack rises.
  - R_ack stuck at 1: no new output handshake starts.
  - rst_n asserted mid-handshake: all state clears on that edge, regardless of req/ack levels.

Optional Feature:
- SUM_SIGNED_EN defined:
  - Operands are two's complement and are sign-extended to WIDTH_OUT before the add.
  - Example: 8'hFF + 8'h01 → 13'h0000.
- SUM_SIGNED_EN not defined:
  - Zero-extension as above.
  - Example: 8'hFF + 8'h01 → 13'h0100.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with all reqs=1 → L1_ack=L2_ack=R_req=0 and R_data=0 after release edge.
- Basic handshake:
  - L1_data=8'd100, L2_data=8'd55, both req=1, R_ack=0 → R_req=1 two cycles later, R_data=13'd155, L1_ack=L2_ack=1.
  - Then reqs=0 and R_ack=1 → all acks/req return to 0 within 2 cycles; R_data stays 155.
- Max values: 8'hFF + 8'hFF (unsigned) → R_data=13'h01FE. With SUM_SIGNED_EN → 13'h1FFE (-2).
- Single request: L1_req=1, L2_req=0 for 10 cycles → R_req stays 0. Raising L2_req then produces R_req=1 two cycles later.
- Back-pressure: R_ack held 1 while both reqs rise → R_req stays 0. Dropping R_ack → R_req=1 one cycle later with current sum.
- Mid-handshake reset: assert rst_n=0 while s=1 → next cycle R_req=0, acks=0, R_data=0.

Source files
------------

// File: rtl/sync_sum_join_if.sv
// Channel bundle for sync_sum_join: two 4-phase input channels (L1, L2) and one output channel (R).
// The master is the environment side; the slave is the join-and-add stage.
interface sync_sum_join_if #(
    parameter int WIDTH_IN  = 8,
    parameter int WIDTH_OUT = 13
);
    logic                 L1_req;
    logic [WIDTH_IN-1:0]  L1_data;
    logic                 L1_ack;
    logic                 L2_req;
    logic [WIDTH_IN-1:0]  L2_data;
    logic                 L2_ack;
    logic                 R_req;
    logic [WIDTH_OUT-1:0] R_data;
    logic                 R_ack;

    modport master (
        output L1_req, L1_data, L2_req, L2_data, R_ack,
        input  L1_ack, L2_ack, R_req, R_data
    );

    modport slave (
        input  L1_req, L1_data, L2_req, L2_data, R_ack,
        output L1_ack, L2_ack, R_req, R_data
    );
endinterface

// File: rtl/sync_sum_join.sv
// Clocked two-input join-and-add stage with 4-phase req/ack on every channel.
// Define SUM_SIGNED_EN to treat operands as two's complement (sign-extended before the add).
module sync_sum_join #(
    parameter int WIDTH_IN  = 8,
    parameter int WIDTH_OUT = 13
) (
    input  logic            clk,
    input  logic            rst_n,
    sync_sum_join_if.slave  bus
);
    if (WIDTH_OUT < WIDTH_IN + 1) begin : g_width_check
        $error("sync_sum_join: WIDTH_OUT must be >= WIDTH_IN+1");
    end

    localparam int EXT = WIDTH_OUT - WIDTH_IN;

    logic                 r_j;
    logic                 r_s;
    logic [WIDTH_OUT-1:0] r_data;
    logic                 w_s_next;
    logic [WIDTH_OUT-1:0] w_op1;
    logic [WIDTH_OUT-1:0] w_op2;
    logic [WIDTH_OUT-1:0] w_sum;

`ifdef SUM_SIGNED_EN
    assign w_op1 = {{EXT{bus.L1_data[WIDTH_IN-1]}}, bus.L1_data};
    assign w_op2 = {{EXT{bus.L2_data[WIDTH_IN-1]}}, bus.L2_data};
`else
    assign w_op1 = {{EXT{1'b0}}, bus.L1_data};
    assign w_op2 = {{EXT{1'b0}}, bus.L2_data};
`endif

    assign w_sum = w_op1 + w_op2;

    // Output C-element: joined request gated by the inverted consumer acknowledge.
    always_comb begin
        w_s_next = r_s;
        if (r_j && !bus.R_ack) begin
            w_s_next = 1'b1;
        end else if (!r_j && bus.R_ack) begin
            w_s_next = 1'b0;
        end else begin
            w_s_next = r_s;
        end
    end

    // Input join, output state and the result hold register (captures while s is headed high).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_j    <= 1'b0;
            r_s    <= 1'b0;
            r_data <= {WIDTH_OUT{1'b0}};
        end else begin
            if (bus.L1_req && bus.L2_req) begin
                r_j <= 1'b1;
            end else if (!bus.L1_req && !bus.L2_req) begin
                r_j <= 1'b0;
            end else begin
                r_j <= r_j;
            end
            r_s <= w_s_next;
            if (w_s_next) begin
                r_data <= w_sum;
            end else begin
                r_data <= r_data;
            end
        end
    end

    assign bus.L1_ack = r_s;
    assign bus.L2_ack = r_s;
    assign bus.R_req  = r_s;
    assign bus.R_data = r_data;
endmodule

// File: tb/tb_sync_sum_join.sv
// Directed, table-driven bench for sync_sum_join plus hand-written multi-cycle corner sequences.
module tb_sync_sum_join;
    localparam int WI = 8;
    localparam int WO = 13;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    sync_sum_join_if #(.WIDTH_IN(WI), .WIDTH_OUT(WO)) bus ();

    sync_sum_join #(.WIDTH_IN(WI), .WIDTH_OUT(WO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [WI-1:0] a;
        logic [WI-1:0] b;
        logic [WO-1:0] exp;
    } vec_t;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string name, input logic s, input logic [WO-1:0] d);
        check({name, "_r_req"},  32'(bus.R_req),  32'(s));
        check({name, "_l1_ack"}, 32'(bus.L1_ack), 32'(s));
        check({name, "_l2_ack"}, 32'(bus.L2_ack), 32'(s));
        check({name, "_r_data"}, 32'(bus.R_data), 32'(d));
    endtask

    // Both requests up with R_ack low; R_req must rise exactly two edges later.
    task automatic raise_pair(input string name, input logic [WI-1:0] a, input logic [WI-1:0] b,
                              input logic [WO-1:0] exp);
        bus.L1_data = a;
        bus.L2_data = b;
        bus.L1_req  = 1'b1;
        bus.L2_req  = 1'b1;
        bus.R_ack   = 1'b0;
        step();
        check({name, "_lat1"}, 32'(bus.R_req), 32'd0);
        step();
        check_outs({name, "_up"}, 1'b1, exp);
    endtask

    task automatic return_to_zero(input string name, input logic [WO-1:0] exp);
        bus.L1_req = 1'b0;
        bus.L2_req = 1'b0;
        bus.R_ack  = 1'b1;
        step();
        check({name, "_rtz1"}, 32'(bus.R_req), 32'd1);
        step();
        check_outs({name, "_rtz2"}, 1'b0, exp);
        bus.R_ack = 1'b0;
        step();
    endtask

    vec_t vecs[7];

    initial begin
        checks   = 0;
        failures = 0;
`ifdef SUM_SIGNED_EN
        vecs[0] = '{a: 8'd100, b: 8'd55,  exp: 13'd155};
        vecs[1] = '{a: 8'hFF,  b: 8'hFF,  exp: 13'h1FFE};
        vecs[2] = '{a: 8'hFF,  b: 8'h01,  exp: 13'h0000};
        vecs[3] = '{a: 8'h00,  b: 8'h00,  exp: 13'h0000};
        vecs[4] = '{a: 8'h80,  b: 8'h80,  exp: 13'h1F00};
        vecs[5] = '{a: 8'h7F,  b: 8'h7F,  exp: 13'h00FE};
        vecs[6] = '{a: 8'd12,  b: 8'd34,  exp: 13'd46};
`else
        vecs[0] = '{a: 8'd100, b: 8'd55,  exp: 13'd155};
        vecs[1] = '{a: 8'hFF,  b: 8'hFF,  exp: 13'h01FE};
        vecs[2] = '{a: 8'hFF,  b: 8'h01,  exp: 13'h0100};
        vecs[3] = '{a: 8'h00,  b: 8'h00,  exp: 13'h0000};
        vecs[4] = '{a: 8'h80,  b: 8'h80,  exp: 13'h0100};
        vecs[5] = '{a: 8'h7F,  b: 8'h7F,  exp: 13'h00FE};
        vecs[6] = '{a: 8'd12,  b: 8'd34,  exp: 13'd46};
`endif

        // Reset held with all requests high.
        rst_n       = 1'b0;
        bus.L1_req  = 1'b1;
        bus.L2_req  = 1'b1;
        bus.L1_data = 8'd5;
        bus.L2_data = 8'd6;
        bus.R_ack   = 1'b0;
        step();
        step();
        check_outs("reset_hold", 1'b0, 13'd0);
        bus.L1_req = 1'b0;
        bus.L2_req = 1'b0;
        rst_n      = 1'b1;
        step();
        check_outs("reset_release", 1'b0, 13'd0);

        for (int i = 0; i < 7; i++) begin
            raise_pair($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].exp);
            return_to_zero($sformatf("vec%0d", i), vecs[i].exp);
        end

        // Single request never joins.
        bus.L1_data = 8'd20;
        bus.L2_data = 8'd22;
        bus.L1_req  = 1'b1;
        bus.L2_req  = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            check($sformatf("single_req_%0d", i), 32'(bus.R_req), 32'd0);
        end
        bus.L2_req = 1'b1;
        step();
        check("single_late1", 32'(bus.R_req), 32'd0);
        step();
        check_outs("single_late2", 1'b1, 13'd42);
        return_to_zero("single", 13'd42);

        // Back-pressure: R_ack stuck high blocks the output event.
        bus.L1_data = 8'd7;
        bus.L2_data = 8'd9;
        bus.R_ack   = 1'b1;
        bus.L1_req  = 1'b1;
        bus.L2_req  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check($sformatf("bp_hold_%0d", i), 32'(bus.R_req), 32'd0);
        end
        check("bp_data_hold", 32'(bus.R_data), 32'd42);
        bus.R_ack = 1'b0;
        step();
        check_outs("bp_release", 1'b1, 13'd16);
        return_to_zero("bp", 13'd16);

        // Request pair drops before the consumer acknowledges: s stays up.
        raise_pair("drop", 8'd30, 8'd40, 13'd70);
        bus.L1_req = 1'b0;
        bus.L2_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("drop_hold_%0d", i), 32'(bus.R_req), 32'd1);
        end
        bus.R_ack = 1'b1;
        step();
        check_outs("drop_ack", 1'b0, 13'd70);
        bus.R_ack = 1'b0;
        step();

        // Reset in the middle of an active handshake.
        raise_pair("midrst", 8'd3, 8'd4, 13'd7);
        rst_n = 1'b0;
        step();
        check_outs("midrst_clear", 1'b0, 13'd0);
        bus.L1_req = 1'b0;
        bus.L2_req = 1'b0;
        rst_n      = 1'b1;
        step();
        check_outs("midrst_after", 1'b0, 13'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
